load_store_unit: RTL and testbench



---
 rtl/load_store_unit_if.sv | 61 ++++++
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the request/response handshake and the byte-memory bus of the
// load/store unit into a single interface.
//   slave  : the load/store unit's view (takes requests, drives memory)
//   master : requester plus memory model (issues requests, returns mem_out)
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata : request handshake
//   req_size   : 0 = word, 1 = byte (only with LSU_BYTE_OP_EN defined)
//   resp_valid/resp_rdata                         : completion pulse + load data
//   mem_addr/mem_in/mem_we/mem_out                : 256-entry byte memory port
// Optional feature macro: LSU_BYTE_OP_EN
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [27:0] req_addr;
    logic [27:0] req_wdata;
`ifdef LSU_BYTE_OP_EN
    logic        req_size;
`endif
    logic        resp_valid;
    logic [27:0] resp_rdata;
    logic [27:0] mem_addr;
    logic [27:0] mem_in;
    logic        mem_we;
    logic [27:0] mem_out;

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
`ifdef LSU_BYTE_OP_EN
        input  req_size,
`endif
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output mem_addr,
        output mem_in,
        output mem_we,
        input  mem_out
    );

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
`ifdef LSU_BYTE_OP_EN
        output req_size,
`endif
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  mem_addr,
        input  mem_in,
        input  mem_we,
        output mem_out
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Sequences one 28-bit word load/store into four little-endian byte beats on
// a 256-entry byte memory (addresses wrap within 8 bits), then issues a
// one-cycle completion pulse carrying the reassembled load word.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : load_store_unit_if.slave (request, response and memory signals)
// Optional feature macro: LSU_BYTE_OP_EN adds single-beat byte accesses
// selected by bus.req_size.
module load_store_unit #(
    parameter int BEATS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    state_t      state;
    state_t      next_state;
    logic [1:0]  beat;
    logic        lat_we;
    logic [7:0]  lat_base;
    logic [27:0] lat_wdata;
    logic [23:0] load_buf;
    logic [27:0] rdata;
    logic [7:0]  beat_addr;
    logic [7:0]  store_byte;
    logic        last_beat;
    logic        unused_bits;
`ifdef LSU_BYTE_OP_EN
    logic        lat_size;

    assign last_beat = (beat == LAST_BEAT) || lat_size;
`else
    assign last_beat = (beat == LAST_BEAT);
`endif

    // Only the low address byte and the low memory byte carry information.
    assign unused_bits = ^{bus.req_addr[27:8], bus.mem_out[27:8]};

    // Byte address of the current beat; 8-bit addition wraps 0xFF -> 0x00.
    assign beat_addr = lat_base + {6'b0, beat};

    assign bus.resp_rdata = rdata;

    // Pick the store byte for the current beat; the top beat only carries
    // the four remaining data bits.
    always_comb begin
        store_byte = 8'h00;
        case (beat)
            2'd0:    store_byte = lat_wdata[7:0];
            2'd1:    store_byte = lat_wdata[15:8];
            2'd2:    store_byte = lat_wdata[23:16];
            default: store_byte = {4'b0, lat_wdata[27:24]};
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state and all handshake/memory outputs. Memory outputs are only
    // non-zero in ACCESS, so a reset drops mem_we immediately.
    always_comb begin
        next_state     = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.mem_addr   = 28'h0;
        bus.mem_in     = 28'h0;
        bus.mem_we     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    next_state = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_addr = {20'b0, beat_addr};
                if (lat_we) begin
                    bus.mem_we = 1'b1;
                    bus.mem_in = {20'b0, store_byte};
                end
                if (last_beat) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Request latching, beat counting and load assembly. Load bytes collect
    // in load_buf so resp_rdata keeps the previous word until the final beat
    // of the next load lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat      <= 2'd0;
            lat_we    <= 1'b0;
            lat_base  <= 8'h00;
            lat_wdata <= 28'h0;
            load_buf  <= 24'h0;
            rdata     <= 28'h0;
`ifdef LSU_BYTE_OP_EN
            lat_size  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_base  <= bus.req_addr[7:0];
                        lat_wdata <= bus.req_wdata;
                        beat      <= 2'd0;
`ifdef LSU_BYTE_OP_EN
                        lat_size  <= bus.req_size;
`endif
                    end
                end
                ACCESS: begin
                    beat <= beat + 2'd1;
                    if (!lat_we) begin
                        if (last_beat) begin
`ifdef LSU_BYTE_OP_EN
                            if (lat_size) begin
                                rdata <= {20'b0, bus.mem_out[7:0]};
                            end else begin
                                rdata <= {bus.mem_out[3:0], load_buf};
                            end
`else
                            rdata <= {bus.mem_out[3:0], load_buf};
`endif
                        end else begin
                            case (beat)
                                2'd0:    load_buf[7:0]   <= bus.mem_out[7:0];
                                2'd1:    load_buf[15:8]  <= bus.mem_out[7:0];
                                default: load_buf[23:16] <= bus.mem_out[7:0];
                            endcase
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Drives load_store_unit through a table of word loads/stores, checks every
// completion against a scoreboard of expected read data and latency, checks
// memory contents through a behavioural 256-byte memory, and runs hand-written
// sequences for continuous requests, mid-store reset and (with LSU_BYTE_OP_EN)
// byte accesses.
module tb_load_store_unit;
    logic clk;
    logic rst_n;

    load_store_unit_if bus ();

    load_store_unit #(.BEATS(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural byte memory: combinational read, write at the rising edge.
    logic [7:0] mem [256];
    assign bus.mem_out = {20'b0, mem[bus.mem_addr[7:0]]};
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_in[7:0];
        end
    end

    typedef struct {
        logic [27:0] rdata;
        int          lat;
        int          at;
        string       name;
    } exp_t;

    typedef struct {
        logic        we;
        logic [27:0] addr;
        logic [27:0] wdata;
        logic [27:0] exp_rdata;
        string       name;
    } vec_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } mchk_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          ncnt = 0;
    logic        accepted;
    int          accept_idx;
    logic [27:0] pend_rdata;
    int          pend_lat;
    string       pend_name;

    task automatic checkOutput(input string name, input logic [27:0] act, input logic [27:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle: register an acceptance seen with the current inputs,
    // move to the next falling edge, then compare any completion and the
    // idle-state memory outputs.
    task automatic tick();
        exp_t e;
        if (rst_n && bus.req_valid && bus.req_ready) begin
            e.rdata = pend_rdata;
            e.lat   = pend_lat;
            e.at    = ncnt + 1;
            e.name  = pend_name;
            sb.push_back(e);
            accepted   = 1'b1;
            accept_idx = ncnt;
        end
        @(negedge clk);
        ncnt++;
        if (rst_n && bus.resp_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_resp", 28'd1, 28'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
                checkOutput({e.name, "_latency"}, 28'(ncnt - e.at), 28'(e.lat));
            end
        end
        if (bus.mem_we) begin
            checkOutput("beat_mem_addr_hi", {8'h0, bus.mem_addr[27:8]}, 28'h0);
        end
        if (rst_n && bus.req_ready) begin
            checkOutput("idle_mem_we", {27'h0, bus.mem_we}, 28'h0);
            checkOutput("idle_mem_addr", bus.mem_addr, 28'h0);
            checkOutput("idle_mem_in", bus.mem_in, 28'h0);
        end
    endtask

    task automatic setRequest(input logic we, input logic [27:0] addr, input logic [27:0] wdata,
                              input logic sz, input logic [27:0] exp, input string name);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
`ifdef LSU_BYTE_OP_EN
        bus.req_size  = sz;
`endif
        pend_rdata = exp;
        pend_lat   = sz ? 1 : 4;
        pend_name  = name;
    endtask

    // Present one request until accepted, then scramble the request fields so
    // any use of unlatched inputs shows up in the results.
    task automatic applyStimulus(input logic we, input logic [27:0] addr, input logic [27:0] wdata,
                                 input logic sz, input logic [27:0] exp, input string name);
        setRequest(we, addr, wdata, sz, exp, name);
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            tick();
        end
        if (!accepted) begin
            checkOutput({name, "_accept_timeout"}, 28'd0, 28'd1);
        end
        bus.req_valid = 1'b0;
        bus.req_we    = ~bus.req_we;
        bus.req_addr  = 28'($urandom);
        bus.req_wdata = 28'($urandom);
    endtask

    task automatic waitResponse();
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            checkOutput("resp_timeout", 28'd0, 28'd1);
            sb.delete();
        end
    endtask

    vec_t  vecs[9];
    vec_t  cont[4];
    mchk_t mchk[12];
    int    acc_at[4];

    initial begin
        vecs[0] = '{1'b1, 28'h0000010, 28'hABCDEF1, 28'h0000000, "st_10"};
        vecs[1] = '{1'b0, 28'h0000010, 28'h0000000, 28'hABCDEF1, "ld_10"};
        vecs[2] = '{1'b1, 28'h00000FE, 28'h1234567, 28'hABCDEF1, "st_fe"};
        vecs[3] = '{1'b0, 28'h00000FE, 28'h0000000, 28'h1234567, "ld_fe"};
        vecs[4] = '{1'b1, 28'h0000041, 28'h7654321, 28'h1234567, "st_41"};
        vecs[5] = '{1'b0, 28'h0000041, 28'h0000000, 28'h7654321, "ld_41"};
        vecs[6] = '{1'b0, 28'h0000010, 28'h0000000, 28'hABCDEF1, "ld_10_again"};
        vecs[7] = '{1'b1, 28'h0000020, 28'h1122334, 28'hABCDEF1, "st_20"};
        vecs[8] = '{1'b0, 28'hFFFFF20, 28'h0000000, 28'h1122334, "ld_20_hiaddr"};

        cont[0] = '{1'b1, 28'h0000050, 28'hC0FFEE5, 28'h1122334, "cont_st0"};
        cont[1] = '{1'b0, 28'h0000050, 28'h0000000, 28'hC0FFEE5, "cont_ld0"};
        cont[2] = '{1'b1, 28'h0000050, 28'h3141592, 28'hC0FFEE5, "cont_st1"};
        cont[3] = '{1'b0, 28'h0000050, 28'h0000000, 28'h3141592, "cont_ld1"};

        mchk[0]  = '{8'h10, 8'hF1};
        mchk[1]  = '{8'h11, 8'hDE};
        mchk[2]  = '{8'h12, 8'hBC};
        mchk[3]  = '{8'h13, 8'h0A};
        mchk[4]  = '{8'hFE, 8'h67};
        mchk[5]  = '{8'hFF, 8'h45};
        mchk[6]  = '{8'h00, 8'h23};
        mchk[7]  = '{8'h01, 8'h01};
        mchk[8]  = '{8'h41, 8'h21};
        mchk[9]  = '{8'h42, 8'h43};
        mchk[10] = '{8'h43, 8'h65};
        mchk[11] = '{8'h44, 8'h07};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 28'h0;
        bus.req_wdata = 28'h0;
`ifdef LSU_BYTE_OP_EN
        bus.req_size  = 1'b0;
`endif
        accepted   = 1'b0;
        accept_idx = 0;
        pend_rdata = 28'h0;
        pend_lat   = 4;
        pend_name  = "none";

        repeat (3) @(negedge clk);
        checkOutput("reset_req_ready", {27'h0, bus.req_ready}, 28'd1);
        checkOutput("reset_resp_valid", {27'h0, bus.resp_valid}, 28'd0);
        checkOutput("reset_resp_rdata", bus.resp_rdata, 28'h0);
        checkOutput("reset_mem_we", {27'h0, bus.mem_we}, 28'd0);
        rst_n = 1'b1;
        tick();

        $display("[TB] table-driven word accesses");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, 1'b0,
                          vecs[i].exp_rdata, vecs[i].name);
            waitResponse();
        end
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("mem_%02h", mchk[i].addr),
                        {20'h0, mem[mchk[i].addr]}, {20'h0, mchk[i].data});
        end

        $display("[TB] continuous req_valid, one accept per 6 cycles");
        setRequest(cont[0].we, cont[0].addr, cont[0].wdata, 1'b0, cont[0].exp_rdata, cont[0].name);
        begin
            int r = 0;
            for (int c = 0; c < 60 && r < 4; c++) begin
                accepted = 1'b0;
                tick();
                if (accepted) begin
                    acc_at[r] = accept_idx;
                    r++;
                    if (r < 4) begin
                        setRequest(cont[r].we, cont[r].addr, cont[r].wdata, 1'b0,
                                   cont[r].exp_rdata, cont[r].name);
                    end else begin
                        bus.req_valid = 1'b0;
                    end
                end
            end
            bus.req_valid = 1'b0;
            checkOutput("cont_accept_count", 28'(r), 28'd4);
        end
        waitResponse();
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("cont_interval_%0d", i), 28'(acc_at[i+1] - acc_at[i]), 28'd6);
        end

        $display("[TB] reset during beat 2 of a store");
        applyStimulus(1'b1, 28'h0000020, 28'hFFFFFFF, 1'b0, 28'h3141592, "abort_st");
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("abort_mem_we", {27'h0, bus.mem_we}, 28'd0);
        checkOutput("abort_req_ready", {27'h0, bus.req_ready}, 28'd1);
        tick();
        tick();
        rst_n = 1'b1;
        checkOutput("abort_resp_rdata", bus.resp_rdata, 28'h0);
        repeat (4) tick();
        checkOutput("abort_mem_20", {20'h0, mem[8'h20]}, 28'hFF);
        checkOutput("abort_mem_21", {20'h0, mem[8'h21]}, 28'hFF);
        checkOutput("abort_mem_22", {20'h0, mem[8'h22]}, 28'h12);
        checkOutput("abort_mem_23", {20'h0, mem[8'h23]}, 28'h01);
        applyStimulus(1'b0, 28'h0000020, 28'h0, 1'b0, 28'h112FFFF, "ld_after_abort");
        waitResponse();

`ifdef LSU_BYTE_OP_EN
        $display("[TB] byte accesses");
        applyStimulus(1'b1, 28'h0000030, 28'h0000000, 1'b0, 28'h112FFFF, "st_30_word");
        waitResponse();
        applyStimulus(1'b1, 28'h0000030, 28'h00005A5, 1'b1, 28'h112FFFF, "st_30_byte");
        waitResponse();
        applyStimulus(1'b0, 28'h0000030, 28'h0000000, 1'b1, 28'h00000A5, "ld_30_byte");
        waitResponse();
        checkOutput("byte_mem_30", {20'h0, mem[8'h30]}, 28'hA5);
        checkOutput("byte_mem_31", {20'h0, mem[8'h31]}, 28'h00);
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
